fb_pixel_writer: RTL
====================

// Module: fb_pixel_writer
// PURPOSE
//  Consumer end of the pixel-plot stream produced by the sprite drawers (player/enemy/bullet).
//  Accepts (x,y,colour) plot requests through a valid/ready handshake and buffers them in a small FIFO.
//  Converts each request to a linear framebuffer address and issues one write per cycle to the 160x120x3 frame RAM.
//  Also runs a full-screen clear sweep on request. Sits between the drawer mux and the frame RAM write port.
// PARAMETERS
//  FIFO_DEPTH  8    plot FIFO entries; power of two, >=2
//  SCR_W       160  screen width in pixels
//  SCR_H       120  screen height in pixels
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  reset        in   1   synchronous, active-high
//  plot_valid   in   1   plot request present
//  plot_x       in   8   pixel column
//  plot_y       in   7   pixel row
//  plot_colour  in   3   RGB colour
//  plot_ready   out  1   FIFO can accept; transfer on edge where valid&&ready
//  clear_req    in   1   start clear sweep (level sampled, acted on in IDLE only)
//  clear_colour in   3   fill colour, latched when clear starts
//  clear_busy   out  1   high while sweep in progress
//  clear_done   out  1   one-cycle pulse after last clear write
//  mem_addr     out  15  frame RAM address = y*SCR_W + x
//  mem_data     out  3   frame RAM write data
//  mem_we       out  1   frame RAM write enable, one write per cycle max
//  oob_count    out  8   saturating count of discarded out-of-range plots
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE; mem_we=0, mem_addr=0, mem_data=0, clear_busy=0, clear_done=0, oob_count=0.
//  Reset: plot_ready=0 while reset is high, then 1 on the first cycle after reset.
//  Reset mid-sweep or mid-drain: abort immediately; queued plots are lost.
//  plot_ready = !fifo_full, registered-free (combinational from the count).
//  Push while full: impossible, because ready is low.
//  Push and pop on the same edge: allowed; count is unchanged.
//  No FIFO bypass: a plot accepted at edge k pops at the earliest at edge k+1.
//  Pop timing: if the FIFO was empty, mem_we=1 with that pixel during the cycle after edge k+1.
//  Pop range check: if x>=SCR_W or y>=SCR_H, the entry is dropped with mem_we=0 that cycle.
//  Pop range check: a dropped entry increments oob_count, which saturates at 255. No modulo wrap.
//  Address: (y<<7)+(y<<5)+x computed at 15 bits; max 19199; never truncated.
//  mem_* are registered outputs; mem_we=0 on any cycle with no pop and no clear write.
//  FSM states: IDLE, CLEAR, DONE.
//  IDLE: if clear_req=1, latch clear_colour, set addr counter=0, go to CLEAR. No pop in that cycle.
//  IDLE: otherwise, if the FIFO is non-empty, pop one entry per cycle.
//  IDLE: clear_req beats a non-empty FIFO when both are present on the same cycle.
//  CLEAR: mem_we=1, mem_addr=counter, mem_data=latched colour. Counter increments each cycle, addresses 0..19199.
//  CLEAR: after the write of 19199, go to DONE. clear_busy=1 for all cycles in CLEAR (19200 cycles).
//  CLEAR: clear_req is ignored. FIFO pushes continue while not full; there are no pops during the sweep.
//  DONE: clear_done=1 for exactly one cycle, mem_we=0, then IDLE. Queued plots drain afterwards, drawing over the cleared screen.
//  clear_req held high: after DONE->IDLE a new sweep starts if it is still high. Requesters must pulse it.
// TESTING
//  Single plot (x=3,y=2,c=5) into an empty FIFO:
//    -> exactly one write, mem_we=1, addr=323, data=5, 2 edges after accept.
//  Burst of 12 back-to-back valids with no stalls on pops:
//    -> all 12 written in order, one per cycle; ready never drops (drain rate = fill rate).
//  Clear sweep with clear_colour=0 while 8 plots are pushed during the sweep:
//    -> plot_ready=0 after the 8th push.
//    -> 19200 writes, addr 0..19199, then clear_done pulses.
//    -> the 8 plots are written after the sweep.
//  Out-of-range plots (x=160,y=0) and (x=0,y=120):
//    -> no mem_we, oob_count=2; feed 300 bad plots -> oob_count stays at 255.
//  Corner pixel x=159,y=119 -> addr=19199. x=0,y=0 -> addr=0.
//  reset asserted at sweep address 5000 with 3 queued plots:
//    -> next cycle mem_we=0, clear_busy=0, FIFO empty, no clear_done pulse.

Source files
------------

// File: rtl/fb_pixel_writer.sv
// Pixel-plot sink for the sprite drawers: buffers (x,y,colour) requests in a small FIFO,
// turns each into a linear frame RAM write, and runs full-screen clear sweeps on request.
module fb_pixel_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int SCR_W      = 160,
  parameter int SCR_H      = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        plot_valid,
  input  logic [7:0]  plot_x,
  input  logic [6:0]  plot_y,
  input  logic [2:0]  plot_colour,
  output logic        plot_ready,
  input  logic        clear_req,
  input  logic [2:0]  clear_colour,
  output logic        clear_busy,
  output logic        clear_done,
  output logic [14:0] mem_addr,
  output logic [2:0]  mem_data,
  output logic        mem_we,
  output logic [7:0]  oob_count
);

  // Handshake: a plot transfers on the rising edge where plot_valid && plot_ready;
  // plot_valid may be held, the payload must be stable while it is high and not yet taken.

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [7:0]    SCR_W_X   = 8'(SCR_W);
  localparam logic [6:0]    SCR_H_Y   = 7'(SCR_H);
  localparam logic [14:0]   SCR_W_A   = 15'(SCR_W);
  localparam logic [14:0]   LAST_ADDR = 15'(SCR_W * SCR_H - 1);
  localparam logic [7:0]    OOB_MAX   = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [17:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [14:0] mem_addr_q, mem_addr_d;
  logic [2:0]  mem_data_q, mem_data_d;
  logic        mem_we_q, mem_we_d;
  logic [7:0]  oob_q, oob_d;
  logic [2:0]  clr_colour_q, clr_colour_d;

  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic [17:0] head;
  logic [7:0]  head_x;
  logic [6:0]  head_y;
  logic [2:0]  head_c;
  logic        head_in_range;
  logic [14:0] head_addr;

  // ---------------------------------------------------------------- FIFO
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign plot_ready = !fifo_full && !reset;
  assign push       = plot_valid && plot_ready;

  // Storage needs no reset: entries are only read while count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {plot_x, plot_y, plot_colour};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------- head decode
  assign head          = fifo_mem[rd_ptr_q];
  assign head_x        = head[17:10];
  assign head_y        = head[9:3];
  assign head_c        = head[2:0];
  assign head_in_range = (head_x < SCR_W_X) && (head_y < SCR_H_Y);
  assign head_addr     = (15'(head_y) * SCR_W_A) + 15'(head_x);

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (mem_addr_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- FSM: outputs and datapath
  // During a sweep mem_addr_q is the sweep counter, so each CLEAR cycle shows the write it makes.
  always_comb begin
    pop          = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    oob_d        = oob_q;
    clr_colour_d = clr_colour_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          clr_colour_d = clear_colour;
          mem_we_d     = 1'b1;
          mem_addr_d   = '0;
          mem_data_d   = clear_colour;
        end else if (!fifo_empty) begin
          pop = 1'b1;
          if (head_in_range) begin
            mem_we_d   = 1'b1;
            mem_addr_d = head_addr;
            mem_data_d = head_c;
          end else if (oob_q != OOB_MAX) begin
            oob_d = oob_q + 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        if (mem_addr_q != LAST_ADDR) begin
          mem_we_d   = 1'b1;
          mem_addr_d = mem_addr_q + 1'b1;
          mem_data_d = clr_colour_q;
        end
      end
      default: begin
        mem_we_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    clear_busy = (state_q == ST_CLEAR);
    clear_done = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      oob_q        <= '0;
      clr_colour_q <= '0;
    end else begin
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      oob_q        <= oob_d;
      clr_colour_q <= clr_colour_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign oob_count = oob_q;

endmodule
